// File: rtl/test_packet_scheduler_pkg.sv
// Shared types and limits for the test-packet scheduler.
package test_packet_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_GAP     = 3'd4
  } sched_state_e;

  localparam int MIN_PKT_LEN = 4;
  localparam int MIN_GAP     = 2;

endpackage

// File: rtl/test_packet_scheduler_down_counter.sv
// Loadable down counter with a zero flag; holds at zero instead of wrapping.
module sched_down_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load)                    cnt_d = i_load_val;
    else if (i_dec && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/test_packet_scheduler.sv
// Frames LFSR payload bursts into test packets: seed pulse, L-byte enables,
// inter-packet gaps, SOF/EOF marking and a sent-packet counter.
module test_packet_scheduler
  import test_packet_scheduler_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int GAP_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [LEN_W-1:0] i_pkt_len,
  input  logic [GAP_W-1:0] i_gap_len,
  input  logic [CNT_W-1:0] i_pkt_num,
  input  logic             i_tx_busy,
  output logic             o_gen_rst_seed,
  output logic             o_gen_enable,
  output logic             o_tx_valid,
  output logic             o_tx_sof,
  output logic             o_tx_eof,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pkts_sent
);

  sched_state_e     state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] pkts_q, pkts_d;
  logic             stop_q, stop_d;
  logic             seed_q, seed_d;
  logic             en_q, en_d;
  logic             val_q, val_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic byte_load, byte_dec, byte_zero;
  logic gap_load, gap_dec, gap_zero;
  logic stop_now;

  // Byte counter holds L-1..0 so the zero flag marks the last payload cycle.
  sched_down_counter #(.W(LEN_W)) u_byte_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (byte_load),
    .i_load_val (len_q - LEN_W'(1)),
    .i_dec      (byte_dec),
    .o_zero     (byte_zero)
  );

  // The WAIT_TX cycle that follows every gap is the final idle cycle, so GAP itself runs G-1 cycles.
  sched_down_counter #(.W(GAP_W)) u_gap_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (gap_load),
    .i_load_val (gap_q - GAP_W'(2)),
    .i_dec      (gap_dec),
    .o_zero     (gap_zero)
  );

  assign stop_now = stop_q | i_stop;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    gap_d     = gap_q;
    num_d     = num_q;
    pkts_d    = pkts_q;
    seed_d    = 1'b0;
    done_d    = 1'b0;
    byte_load = 1'b0;
    byte_dec  = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          len_d   = (i_pkt_len < LEN_W'(MIN_PKT_LEN)) ? LEN_W'(MIN_PKT_LEN) : i_pkt_len;
          gap_d   = (i_gap_len < GAP_W'(MIN_GAP)) ? GAP_W'(MIN_GAP) : i_gap_len;
          num_d   = i_pkt_num;
          pkts_d  = '0;
          seed_d  = 1'b1;
          state_d = ST_SEED;
        end
      end
      ST_SEED: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (stop_now) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (!i_tx_busy) begin
          byte_load = 1'b1;
          state_d   = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        byte_dec = 1'b1;
        if (byte_zero) begin
          gap_load = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_dec = 1'b1;
        if (gap_zero) begin
          if (stop_now || (num_q != '0 && pkts_q == num_q)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_TX;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    stop_d = (state_q != ST_IDLE) && (state_d != ST_IDLE) && stop_now;
    en_d   = (state_d == ST_PAYLOAD);
    busy_d = (state_d != ST_IDLE);
    val_d  = en_q;
    // Bursts are always separated by WAIT_TX, so a rising enable is the first byte.
    sof_d  = en_q && !val_q;
    eof_d  = en_q && byte_zero;
    if (eof_d && pkts_q != '1) pkts_d = pkts_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      gap_q   <= '0;
      num_q   <= '0;
      pkts_q  <= '0;
      stop_q  <= 1'b0;
      seed_q  <= 1'b0;
      en_q    <= 1'b0;
      val_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      num_q   <= num_d;
      pkts_q  <= pkts_d;
      stop_q  <= stop_d;
      seed_q  <= seed_d;
      en_q    <= en_d;
      val_q   <= val_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_gen_rst_seed = seed_q;
  assign o_gen_enable   = en_q;
  assign o_tx_valid     = val_q;
  assign o_tx_sof       = sof_q;
  assign o_tx_eof       = eof_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_pkts_sent    = pkts_q;

endmodule

// File: tb/tb_test_packet_scheduler.sv
// Randomized and directed bench for test_packet_scheduler against a cycle-schedule model.
module tb_test_packet_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0, i_stop = 1'b0, i_tx_busy = 1'b0;
  logic [15:0] i_pkt_len = '0, i_gap_len = '0;
  logic [31:0] i_pkt_num = '0;
  logic        o_gen_rst_seed, o_gen_enable, o_tx_valid, o_tx_sof, o_tx_eof, o_busy, o_done;
  logic [31:0] o_pkts_sent;

  int n_cmp = 0, n_bad = 0;

  test_packet_scheduler #(.LEN_W(16), .GAP_W(16), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_pkt_len(i_pkt_len), .i_gap_len(i_gap_len), .i_pkt_num(i_pkt_num),
    .i_tx_busy(i_tx_busy), .o_gen_rst_seed(o_gen_rst_seed), .o_gen_enable(o_gen_enable),
    .o_tx_valid(o_tx_valid), .o_tx_sof(o_tx_sof), .o_tx_eof(o_tx_eof),
    .o_busy(o_busy), .o_done(o_done), .o_pkts_sent(o_pkts_sent)
  );

  always #5 clk = ~clk;

  // Model: a run is a timeline of absolute cycle numbers. A burst starting at
  // cycle bs has enable on [bs, bs+L-1], valid on [bs+1, bs+L], gap through
  // bs+L+G-2; the cycle after that is a transmit-wait decision cycle.
  longint cyc, m_wait, m_bs, nx;
  bit     m_act, m_stop;
  int     m_L, m_G;
  logic [31:0] m_N, m_sent;
  logic   e_seed, e_en, e_val, e_sof, e_eof, e_busy, e_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_wait = -1; m_bs = -1; m_act = 0; m_stop = 0;
      m_L = 0; m_G = 0; m_N = 0; m_sent = 0;
      {e_seed, e_en, e_val, e_sof, e_eof, e_busy, e_done} = '0;
    end else begin
      e_seed = 0; e_done = 0;
      if (!m_act) begin
        if (i_start && !i_stop) begin
          m_act = 1; m_stop = 0; m_sent = 0; m_N = i_pkt_num;
          m_L = (i_pkt_len < 4) ? 4 : int'(i_pkt_len);
          m_G = (i_gap_len < 2) ? 2 : int'(i_gap_len);
          m_wait = cyc + 2; m_bs = -1; e_seed = 1;
        end
      end else begin
        if (i_stop) m_stop = 1;
        if (m_wait >= 0 && cyc >= m_wait) begin
          if (m_stop) begin m_act = 0; e_done = 1; m_wait = -1; end
          else if (!i_tx_busy) begin m_bs = cyc + 1; m_wait = -1; end
        end else if (m_bs >= 0 && cyc == m_bs + m_L + m_G - 2) begin
          if (m_stop || (m_N != 0 && m_sent == m_N)) begin m_act = 0; e_done = 1; end
          else m_wait = cyc + 1;
          m_bs = -1;
        end
      end
      nx = cyc + 1;
      e_en  = (m_bs >= 0) && nx >= m_bs && nx <= m_bs + m_L - 1;
      e_val = (m_bs >= 0) && nx >= m_bs + 1 && nx <= m_bs + m_L;
      e_sof = (m_bs >= 0) && nx == m_bs + 1;
      e_eof = (m_bs >= 0) && nx == m_bs + m_L;
      if (e_eof && m_sent != 32'hFFFF_FFFF) m_sent = m_sent + 1;
      e_busy = m_act;
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ({o_gen_rst_seed, o_gen_enable, o_tx_valid, o_tx_sof, o_tx_eof, o_busy, o_done} !==
          {e_seed, e_en, e_val, e_sof, e_eof, e_busy, e_done} || o_pkts_sent !== m_sent) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t got seed/en/val/sof/eof/busy/done=%b sent=%0d want %b sent=%0d",
                 $time, {o_gen_rst_seed, o_gen_enable, o_tx_valid, o_tx_sof, o_tx_eof, o_busy, o_done},
                 o_pkts_sent, {e_seed, e_en, e_val, e_sof, e_eof, e_busy, e_done}, m_sent);
      end
    end
  end

  // Event counters observed from the DUT, used for hand-computed expectations.
  int ob_seed = 0, ob_en = 0, ob_val = 0, ob_sof = 0, ob_eof = 0, ob_done = 0, ob_rise = 0;
  bit prev_en = 0;
  always @(negedge clk) begin
    if (rst) prev_en = 0;
    else begin
      ob_seed += int'(o_gen_rst_seed); ob_en += int'(o_gen_enable); ob_val += int'(o_tx_valid);
      ob_sof += int'(o_tx_sof); ob_eof += int'(o_tx_eof); ob_done += int'(o_done);
      ob_rise += int'(o_gen_enable && !prev_en);
      prev_en = o_gen_enable;
    end
  end

  int b_seed, b_en, b_val, b_sof, b_eof, b_done, b_rise;
  task automatic snap();
    b_seed = ob_seed; b_en = ob_en; b_val = ob_val; b_sof = ob_sof;
    b_eof = ob_eof; b_done = ob_done; b_rise = ob_rise;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_run(input int len, input int gap, input int num);
    i_pkt_len = 16'(len); i_gap_len = 16'(gap); i_pkt_num = 32'(num);
    i_start = 1; tick(); i_start = 0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while (o_busy && k < bound) begin tick(); k++; end
    if (o_busy) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout got busy=1 want busy=0 within %0d cycles", name, bound);
    end
  endtask

  initial begin
    tick(3);
    rst = 0;
    tick();
    check("reset_busy", o_busy, 0);
    check("reset_sent", o_pkts_sent, 0);
    check("reset_outs", {o_gen_rst_seed, o_gen_enable, o_tx_valid, o_tx_sof, o_tx_eof, o_done}, 0);

    // 1) len 8, gap 3, two packets
    snap();
    start_run(8, 3, 2);
    check("t1_seed_t1", o_gen_rst_seed, 1);
    tick();
    check("t1_en_t2", o_gen_enable, 0);
    tick();
    check("t1_en_t3", o_gen_enable, 1);
    wait_idle("t1", 200);
    tick();
    check("t1_seeds", ob_seed - b_seed, 1);
    check("t1_en_cycles", ob_en - b_en, 16);
    check("t1_valid", ob_val - b_val, 16);
    check("t1_sof", ob_sof - b_sof, 2);
    check("t1_eof", ob_eof - b_eof, 2);
    check("t1_bursts", ob_rise - b_rise, 2);
    check("t1_done", ob_done - b_done, 1);
    check("t1_sent", o_pkts_sent, 2);

    // 2) clamped length and gap
    snap();
    start_run(1, 0, 1);
    wait_idle("t2", 100);
    tick();
    check("t2_en_cycles", ob_en - b_en, 4);
    check("t2_sent", o_pkts_sent, 1);

    // 3) tx busy holds off the first burst; busy mid-payload is ignored
    snap();
    i_tx_busy = 1;
    start_run(6, 2, 1);
    tick(9);
    check("t3_held", ob_en - b_en, 0);
    i_tx_busy = 0;
    @(negedge clk);
    check("t3_en_same", o_gen_enable, 0);
    tick();
    check("t3_en_next", o_gen_enable, 1);
    tick(2);
    i_tx_busy = 1;
    wait_idle("t3", 100);
    i_tx_busy = 0;
    tick();
    check("t3_burst_len", ob_en - b_en, 6);

    // 4) continuous mode, stop during third packet
    snap();
    start_run(6, 3, 0);
    begin
      int k = 0;
      while (ob_rise - b_rise < 3 && k < 300) begin tick(); k++; end
    end
    tick();
    i_stop = 1; tick(); i_stop = 0;
    wait_idle("t4", 100);
    tick();
    check("t4_sent", o_pkts_sent, 3);
    check("t4_eof", ob_eof - b_eof, 3);
    check("t4_done", ob_done - b_done, 1);

    // 5) start with stop is ignored; start while busy is ignored
    snap();
    i_start = 1; i_stop = 1; tick(); i_start = 0; i_stop = 0;
    tick(3);
    check("t5_no_seed", ob_seed - b_seed, 0);
    check("t5_idle", o_busy, 0);
    start_run(5, 2, 2);
    tick(4);
    start_run(5, 2, 2);
    wait_idle("t5", 100);
    tick();
    check("t5_one_seed", ob_seed - b_seed, 1);
    check("t5_sent", o_pkts_sent, 2);

    // 6) async reset mid-payload, then a clean run
    start_run(10, 2, 1);
    tick(5);
    check("t6_in_payload", o_gen_enable, 1);
    #1 rst = 1;
    #1;
    check("t6_en_drop", o_gen_enable, 0);
    check("t6_val_drop", o_tx_valid, 0);
    tick(2);
    rst = 0;
    snap();
    start_run(10, 2, 1);
    wait_idle("t6", 100);
    tick();
    check("t6_seed", ob_seed - b_seed, 1);
    check("t6_en_cycles", ob_en - b_en, 10);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      int num, limit, k;
      num = $urandom_range(0, 4);
      limit = $urandom_range(10, 120);
      i_tx_busy = ($urandom_range(0, 3) == 0);
      start_run($urandom_range(0, 12), $urandom_range(0, 6), num);
      k = 0;
      while ((o_busy || k < 2) && k < 800) begin
        i_tx_busy = ($urandom_range(0, 3) == 0);
        i_pkt_len = 16'($urandom_range(0, 20));
        i_gap_len = 16'($urandom_range(0, 9));
        i_stop = ((num == 0 && k == limit) || $urandom_range(0, 199) == 0);
        i_start = ($urandom_range(0, 49) == 0);
        tick();
        k++;
      end
      i_stop = 0; i_start = 0; i_tx_busy = 0;
      if (o_busy) begin
        n_cmp++; n_bad++;
        $display("FAIL rand_timeout got busy=1 want busy=0 run %0d", r);
        i_stop = 1; tick(); i_stop = 0;
        wait_idle("rand_recover", 200);
      end
      tick($urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
